// File: rtl/simd_mac_pipelined_if.sv
// Operand/result handshake bundle for simd_mac_pipelined.
// master = upstream fetch + downstream result consumer, slave = the MAC block.
interface simd_mac_pipelined_if #(
    parameter int unsigned LANE_W = 9,
    parameter int unsigned LANES  = 3,
    parameter int unsigned ACC_W  = 64
);
    localparam int unsigned VEC_W = LANE_W * LANES * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic             a_sign;
    logic             b_sign;
    logic [1:0]       mode;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, a, b, a_sign, b_sign, mode, acc_clear, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b, a_sign, b_sign, mode, acc_clear, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/simd_mac_pipelined.sv
// 3-stage SIMD multiplier: one wide square product or a LANES*LANES-lane dot
// product, with optional accumulation into a wide register with sticky overflow.
module simd_mac_pipelined #(
    parameter int unsigned LANE_W = 9,
    parameter int unsigned LANES  = 3,
    parameter int unsigned ACC_W  = 64
) (
    input logic                 clk,
    input logic                 reset,
    simd_mac_pipelined_if.slave bus
);
    localparam int unsigned OP_W  = LANE_W * LANES;
    localparam int unsigned VEC_W = OP_W * LANES;
    localparam int unsigned NPP   = LANES * LANES;
    localparam int unsigned PP_W  = 2 * (LANE_W + 1);
    localparam int unsigned MSB   = ACC_W - 1;

    if (ACC_W < 2 * OP_W) begin : g_bad_acc_w
        $error("simd_mac_pipelined: ACC_W must be >= 2*LANE_W*LANES");
    end

    // Lane widened by one bit: sign bit when the operand is signed, zero otherwise.
    function automatic logic signed [PP_W-1:0] lane_ext(input logic [VEC_W-1:0] v,
                                                        input int unsigned idx,
                                                        input logic sgn);
        logic [LANE_W-1:0] l;
        l = v[idx*LANE_W +: LANE_W];
        return PP_W'(signed'({sgn & l[LANE_W-1], l}));
    endfunction

    logic stall;
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    logic             s1_valid, s1_a_sign, s1_b_sign, s1_clear;
    logic [VEC_W-1:0] s1_a, s1_b;
    logic [1:0]       s1_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_mode   <= '0;
            s1_clear  <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= bus.in_valid;
            s1_a      <= bus.a;
            s1_b      <= bus.b;
            s1_a_sign <= bus.a_sign;
            s1_b_sign <= bus.b_sign;
            s1_mode   <= bus.mode;
            s1_clear  <= bus.acc_clear;
        end
    end

    // DOT pairs lane i with lane i; FULL forms every cross product of the low
    // LANES lanes, where only the top lane of each operand carries the sign.
    logic signed [PP_W-1:0] pp_c [NPP];

    always_comb begin
        pp_c = '{default: '0};
        for (int unsigned i = 0; i < NPP; i++) begin
            if (s1_mode[0]) begin
                pp_c[i] = lane_ext(s1_a, i, s1_a_sign) * lane_ext(s1_b, i, s1_b_sign);
            end else begin
                pp_c[i] = lane_ext(s1_a, i / LANES, s1_a_sign && (i / LANES == LANES - 1))
                        * lane_ext(s1_b, i % LANES, s1_b_sign && (i % LANES == LANES - 1));
            end
        end
    end

    logic                   s2_valid, s2_dot, s2_acc, s2_signed, s2_clear;
    logic signed [PP_W-1:0] s2_pp [NPP];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_dot    <= 1'b0;
            s2_acc    <= 1'b0;
            s2_signed <= 1'b0;
            s2_clear  <= 1'b0;
            for (int unsigned i = 0; i < NPP; i++) s2_pp[i] <= '0;
        end else if (!stall) begin
            s2_valid  <= s1_valid;
            s2_dot    <= s1_mode[0];
            s2_acc    <= s1_mode[1];
            s2_signed <= s1_a_sign | s1_b_sign;
            s2_clear  <= s1_clear;
            for (int unsigned i = 0; i < NPP; i++) s2_pp[i] <= pp_c[i];
        end
    end

    // Exact sum modulo 2^ACC_W; ACC_W covers the full product and dot ranges.
    logic [ACC_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            if (s2_dot) begin
                sum_c = sum_c + ACC_W'(s2_pp[i]);
            end else begin
                sum_c = sum_c + (ACC_W'(s2_pp[i]) << ((i / LANES + i % LANES) * LANE_W));
            end
        end
    end

    logic [ACC_W-1:0] acc_q, result_q, base_c;
    logic [ACC_W:0]   add_c;
    logic             out_valid_q, ovf_q, ovf_det_c;

    always_comb begin
        base_c    = s2_clear ? '0 : acc_q;
        add_c     = {1'b0, base_c} + {1'b0, sum_c};
        ovf_det_c = s2_signed ? ((base_c[MSB] == sum_c[MSB]) && (add_c[MSB] != base_c[MSB]))
                              : add_c[ACC_W];
    end

    // Accumulator moves only on an S3 load, so a held result is never re-added.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                if (s2_acc) begin
                    acc_q    <= add_c[MSB:0];
                    result_q <= add_c[MSB:0];
                    ovf_q    <= (ovf_q & ~s2_clear) | ovf_det_c;
                end else begin
                    result_q <= sum_c;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_simd_mac_pipelined.sv
// Scoreboard bench for simd_mac_pipelined: a 64-bit accumulator instance for the
// main modes/backpressure and a 56-bit instance for overflow and mid-stream reset.
module tb_simd_mac_pipelined;
    localparam int unsigned LANE_W = 9;
    localparam int unsigned LANES  = 3;

    typedef struct {
        logic [63:0] res;
        bit          ovf;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    simd_mac_pipelined_if #(.LANE_W(LANE_W), .LANES(LANES), .ACC_W(64)) bus_a ();
    simd_mac_pipelined_if #(.LANE_W(LANE_W), .LANES(LANES), .ACC_W(56)) bus_b ();

    simd_mac_pipelined #(.LANE_W(LANE_W), .LANES(LANES), .ACC_W(64)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a));
    simd_mac_pipelined #(.LANE_W(LANE_W), .LANES(LANES), .ACC_W(56)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b));

    exp_t q_a[$], q_b[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    logic signed [127:0] macc [2];
    bit   movf [2];
    bit   rand_done;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Lane value as an integer: two's complement when signed, plain binary otherwise.
    function automatic logic signed [127:0] lane_val(input logic [80:0] v, input int idx,
                                                    input int w, input bit s);
        logic signed [127:0] x;
        x = 128'(v >> (idx * LANE_W)) & ((128'sd1 <<< w) - 128'sd1);
        if (s && x[w-1]) x = x - (128'sd1 <<< w);
        return x;
    endfunction

    function automatic void model(input int d, input int w, input logic [80:0] a, input logic [80:0] b,
                                  input bit as, input bit bs, input logic [1:0] mode, input bit clr,
                                  output logic [63:0] res, output bit ovf);
        logic signed [127:0] p, base, sb, tru, mask;
        mask = (128'sd1 <<< w) - 128'sd1;
        p = 0;
        if (mode[0]) begin
            for (int i = 0; i < 9; i++) p = p + lane_val(a, i, 9, as) * lane_val(b, i, 9, bs);
        end else begin
            p = lane_val(a, 0, 27, as) * lane_val(b, 0, 27, bs);
        end
        if (mode[1]) begin
            base = clr ? 128'sd0 : macc[d];
            if (clr) movf[d] = 1'b0;
            if (as || bs) begin
                sb = base;
                if (sb[w-1]) sb = sb - (128'sd1 <<< w);
                tru = sb + p;
                if (tru >= (128'sd1 <<< (w - 1)) || tru < -(128'sd1 <<< (w - 1))) movf[d] = 1'b1;
            end else begin
                tru = base + p;
                if (tru >= (128'sd1 <<< w)) movf[d] = 1'b1;
            end
            macc[d] = tru & mask;
            res = 64'(macc[d]);
        end else begin
            res = 64'(p & mask);
        end
        ovf = movf[d];
    endfunction

    function automatic logic [80:0] rep(input logic [8:0] l);
        logic [80:0] v;
        for (int i = 0; i < 9; i++) v[i*9 +: 9] = l;
        return v;
    endfunction

    task automatic drive(input int d, input bit v, input logic [80:0] a, input logic [80:0] b,
                         input bit as, input bit bs, input logic [1:0] mode, input bit clr);
        if (d == 0) begin
            bus_a.in_valid = v; bus_a.a = a; bus_a.b = b; bus_a.a_sign = as;
            bus_a.b_sign = bs; bus_a.mode = mode; bus_a.acc_clear = clr;
        end else begin
            bus_b.in_valid = v; bus_b.a = a; bus_b.b = b; bus_b.a_sign = as;
            bus_b.b_sign = bs; bus_b.mode = mode; bus_b.acc_clear = clr;
        end
    endtask

    // Present one transaction, wait for acceptance, and queue its expected response.
    task automatic send(input int d, input logic [80:0] a, input logic [80:0] b, input bit as,
                        input bit bs, input logic [1:0] mode, input bit clr,
                        input bit has_gold, input logic [63:0] gold, input bit lat);
        exp_t e;
        bit   ok;
        int   k, budget;
        budget = 0;
        @(negedge clk);
        drive(d, 1'b1, a, b, as, bs, mode, clr);
        forever begin
            #1;
            ok = (d == 0) ? bus_a.in_ready : bus_b.in_ready;
            k  = cyc;
            @(posedge clk);
            if (ok) break;
            budget++;
            if (budget > 200) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", d);
                break;
            end
            @(negedge clk);
        end
        #1 drive(d, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        if (ok) begin
            model(d, (d == 0) ? 64 : 56, a, b, as, bs, mode, clr, e.res, e.ovf);
            if (has_gold) e.res = gold;
            e.acc_cyc = k;
            e.lat     = lat;
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        end
    endtask

    function automatic void mon(input int d);
        logic ov, orr, ir, of;
        logic [63:0] r;
        exp_t e;
        if (d == 0) begin
            ov = bus_a.out_valid; orr = bus_a.out_ready; ir = bus_a.in_ready;
            r = bus_a.result; of = bus_a.overflow;
        end else begin
            ov = bus_b.out_valid; orr = bus_b.out_ready; ir = bus_b.in_ready;
            r = 64'(bus_b.result); of = bus_b.overflow;
        end
        if (!ov) return;
        if (!orr) begin
            chk("in_ready_during_stall", 64'(ir), 64'd0);
            return;
        end
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output dut%0d: got result %h, required no output", d, r);
            return;
        end
        if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        chk((d == 0) ? "result_a" : "result_b", r, e.res);
        chk((d == 0) ? "overflow_a" : "overflow_b", 64'(of), 64'(e.ovf));
        if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd3);
    endfunction

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_a) mon(0);
        if (rst_b) mon(1);
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [80:0] ones, a_m, b_m;
        int t;
        macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_result", bus_a.result, 64'd0);
        chk("rst_overflow", 64'(bus_a.overflow), 64'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        #1 chk("in_ready_after_rst", 64'(bus_a.in_ready), 64'd1);

        // Wide products and signed/unsigned dot products.
        send(0, 81'h7FFFFFF, 81'h7FFFFFF, 0, 0, 2'd0, 0, 1, 64'h003FFFFFF0000001, 1);
        send(0, 81'h7FFFFFF, 81'h4000000, 1, 1, 2'd0, 0, 1, 64'h0000000004000000, 1);
        send(0, rep(9'h100), rep(9'h100), 1, 1, 2'd1, 0, 1, 64'h0000000000090000, 1);
        send(0, rep(9'h100), rep(9'h100), 0, 0, 2'd1, 0, 1, 64'h0000000000090000, 1);
        send(0, rep(9'h1FF), rep(9'h001), 1, 0, 2'd1, 0, 1, 64'hFFFFFFFFFFFFFFF7, 1);

        // Dot accumulation with clears.
        ones = rep(9'h001);
        for (int k = 0; k < 4; k++) send(0, ones, ones, 0, 0, 2'd3, k == 0, 1, 64'(9 * (k + 1)), 1);
        send(0, ones, ones, 0, 0, 2'd3, 1, 1, 64'd9, 1);
        wait_drain();

        // Back-to-back accumulation with a 5-cycle downstream stall.
        fork
            begin
                for (int k = 0; k < 6; k++) send(0, ones, ones, 0, 0, 2'd3, 0, 1, 64'(9 * (k + 2)), 0);
            end
            begin
                t = 0;
                while (!bus_a.out_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("stall_first_valid", 64'(bus_a.out_valid), 64'd1);
                bus_a.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus_a.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Random transactions under random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    a_m = 81'({$urandom(), $urandom(), $urandom()});
                    b_m = 81'({$urandom(), $urandom(), $urandom()});
                    send(0, a_m, b_m, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, 0, 64'd0, 0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    bus_a.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus_a.out_ready = 1'b1;
            end
        join
        wait_drain();

        // 56-bit accumulator: overflow on reaching 2^55, sticky, cleared by acc_clear.
        a_m = 81'h4000000;
        for (int k = 1; k <= 9; k++) send(1, a_m, a_m, 1, 1, 2'd2, k == 1, 1, 64'(k) << 52, 0);
        wait_drain();
        chk("ovf_sticky", 64'(bus_b.overflow), 64'd1);
        send(1, a_m, a_m, 1, 1, 2'd2, 1, 1, 64'd1 << 52, 0);
        wait_drain();
        chk("ovf_cleared", 64'(bus_b.overflow), 64'd0);
        for (int k = 2; k <= 8; k++) send(1, a_m, a_m, 1, 1, 2'd2, 0, 1, 64'(k) << 52, 0);
        send(1, a_m, a_m, 1, 1, 2'd2, 0, 0, 64'd0, 0);
        send(1, a_m, a_m, 1, 1, 2'd2, 0, 0, 64'd0, 0);
        t = 0;
        while (!(bus_b.out_valid && q_b.size() == 2) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_overflow", 64'(bus_b.overflow), 64'd1);
        #1 rst_b = 1'b0;
        #1;
        chk("reset_out_valid", 64'(bus_b.out_valid), 64'd0);
        chk("reset_result", 64'(bus_b.result), 64'd0);
        chk("reset_overflow", 64'(bus_b.overflow), 64'd0);
        q_b.delete();
        macc[1] = 0;
        movf[1] = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        send(1, a_m, a_m, 1, 1, 2'd2, 0, 1, 64'd1 << 52, 0);
        wait_drain();

        chk("q_a_empty", 64'(q_a.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/simd_mac_pipelined.md
Name: simd_mac_pipelined

Overview:
Parametrised successor to the fixed 27x27 / sum-of-9x9 PIRDSP multiplier. It computes, on each accepted transaction, either one full (LANE_W*LANES)-bit square product or a dot product of LANES*LANES lane-wide products. Either result can optionally feed a wide accumulator with sticky overflow. The block has a 3-stage valid/ready pipeline with full backpressure and sits between the operand fetch logic and the DSP result bus.

Parameters:
LANE_W, 9, width of one sub-multiplier lane (bits)
LANES, 3, lanes per operand side; the block has LANES*LANES sub-products
ACC_W, 64, accumulator and result width; must be >= 2*LANE_W*LANES (elaboration error otherwise)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
in_valid  in  1  input transaction present
in_ready  out  1  block can accept; transfer when in_valid & in_ready
a  in  LANE_W*LANES*LANES  operand A; FULL modes use low LANE_W*LANES bits, DOT modes use all lanes
b  in  LANE_W*LANES*LANES  operand B, same layout as a
a_sign  in  1  A (or each A lane) is two's complement
b_sign  in  1  B (or each B lane) is two's complement
mode  in  2  0=FULL, 1=DOT, 2=FULL_ACC, 3=DOT_ACC
acc_clear  in  1  ACC modes only: start from 0 instead of the current accumulator
out_valid  out  1  result valid
out_ready  in  1  downstream accepts; transfer when out_valid & out_ready
result  out  ACC_W  product, dot sum or accumulator value
overflow  out  1  sticky accumulator overflow flag

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline registers, accumulator, result, out_valid and overflow go to 0.
  - Any in-flight transaction is discarded.
  - in_ready=1 from the first cycle after release.
- Pipeline stages: S1 registers a, b, signs, mode and acc_clear; S2 registers all LANES*LANES lane partial products; S3 is the output register holding result/out_valid.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Stall: stall = out_valid & ~out_ready. While stalled, every stage holds its contents; in_ready = ~stall (combinational). There are no bubbles to collapse, so ordering is strictly preserved.
- Sideband fields (mode, signs, acc_clear) are captured per transaction. Changing mode between back-to-back transactions is legal.
- Signedness:
  - A product is signed if a_sign | b_sign.
  - Mixed signed×unsigned is exact: the unsigned operand is zero-extended by one bit.
- FULL: result = A[LANE_W*LANES-1:0] × B[LANE_W*LANES-1:0], 2*LANE_W*LANES bits, sign- or zero-extended to ACC_W.
- DOT: result = Σ over i of A_lane_i × B_lane_i, for i = 0 .. LANES*LANES-1.
  - Lane i is bits [i*LANE_W +: LANE_W].
  - The sum is exact at 2*LANE_W + clog2(LANES*LANES) bits, then extended to ACC_W.
- ACC modes, applied in S3 when S3 loads:
  - acc_next = (acc_clear ? 0 : acc) + ext(product); the accumulator and result both load acc_next.
- Non-ACC modes leave the accumulator and overflow untouched.
- Overflow detection:
  - Signed transaction: operand signs equal and sum sign differs.
  - Unsigned transaction: carry out of bit ACC_W-1.
  - The accumulator wraps modulo 2^ACC_W; overflow sets and stays set.
- acc_clear in an ACC transaction clears overflow before that transaction's own overflow check.
- The accumulator updates only when S3 loads, never while stalled, so a held result is never double-counted.

Test Plan:
1. FULL unsigned, a=27'h7FFFFFF, b=27'h7FFFFFF -> result=64'h003FFFFFF0000001, out_valid exactly 3 cycles after accept.
2. FULL signed, a=27'h7FFFFFF (-1), b=27'h4000000 (-2^26), both signs=1 -> result=64'h0000000004000000.
3. DOT signed, all 9 lanes a=b=9'h100 (-256) -> result=64'h0000000000090000. Same operands unsigned -> 9*65536 = 64'h90000 as well; then a lanes=9'h1FF, b=9'h001, a_sign=1 -> result=64'hFFFFFFFFFFFFFFF7 (-9).
4. DOT_ACC, 4 transactions with all lanes a=b=1 and acc_clear on the first only -> results 9, 18, 27, 36. A 5th transaction with acc_clear=1 -> result 9.
5. Backpressure: 6 back-to-back transactions with out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 whenever out_valid&~out_ready. All 6 results appear in order, none lost or duplicated, and the accumulator steps once per transaction.
6. ACC_W=56 instance, FULL_ACC signed, a=b=27'h4000000 (each product 2^52), first with acc_clear -> overflow rises on the 8th accept (2^55) and stays 1. A following acc_clear transaction drops overflow to 0. Assert reset mid-stream -> out_valid, result and overflow are 0 immediately, and the next accumulation starts from 0.
